// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns, types and index sizing
// shared by the seven_seg_scan display driver.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // Active-high patterns, bit 6 = a ... bit 0 = g.
    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;

    // Counter width able to hold 0..n-1, never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_scan_decode.sv
// seg_decode: nibble to active-high seven-segment pattern.
// Ports: code (4b) and hex_mode in; seg (7b, a = bit 6) out.
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
            4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
            4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
            4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
            4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
            4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed N-digit seven-segment driver.
// Ports: clk, rst_n, enable, load, digits_in, dp_in, blank_in,
//   lz_suppress in; seg_out, dp_out, an_out, frame_done out.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int REFRESH_DIV     = 50000,
    parameter int HEX_MODE        = 1,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int AN_ACTIVE_HIGH  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_suppress,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_done
);

    localparam int IW = idx_w(N_DIGITS);
    localparam int PW = idx_w(REFRESH_DIV);
    localparam logic HEX = (HEX_MODE != 0);
    localparam seg_t SEG_INV = (SEG_ACTIVE_HIGH != 0) ? '0 : '1;
    localparam logic DP_INV = (SEG_ACTIVE_HIGH == 0);
    localparam logic [N_DIGITS-1:0] AN_INV =
        (AN_ACTIVE_HIGH != 0) ? '0 : '1;

    logic [PW-1:0]         psc;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] pend_dig, act_dig;
    logic [N_DIGITS-1:0]   pend_dp, act_dp;
    logic [N_DIGITS-1:0]   pend_blank, act_blank;
    logic                  pend_valid;
    logic                  tick, wrap, boundary;

    assign tick       = enable && (psc == PW'(REFRESH_DIV - 1));
    assign wrap       = tick && (idx == IW'(N_DIGITS - 1));
    assign frame_done = wrap;
    // While dark every cycle acts as a frame boundary.
    assign boundary   = wrap || !enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
            idx <= '0;
        end else if (!enable) begin
            psc <= '0;
            idx <= '0;
        end else if (tick) begin
            psc <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pend_valid <= 1'b0;
            act_dig    <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
        end else begin
            if (load) begin
                pend_dig   <= digits_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (boundary) begin
                // A load on the boundary bypasses pending.
                if (load) begin
                    act_dig   <= digits_in;
                    act_dp    <= dp_in;
                    act_blank <= blank_in;
                end else if (pend_valid) begin
                    act_dig   <= pend_dig;
                    act_dp    <= pend_dp;
                    act_blank <= pend_blank;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // sup[i]: digit i and every digit above it are zero.
    logic [N_DIGITS-1:0] sup;
    logic                run;

    always_comb begin
        run = 1'b1;
        sup = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run    = run && (act_dig[4*i +: 4] == 4'd0);
            sup[i] = lz_suppress && run && (i != 0);
        end
    end

    logic [3:0] cur_code;
    logic       cur_dp, cur_dark;
    seg_t       cur_seg;

    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code = act_dig[4*i +: 4];
                cur_dp   = act_dp[i];
                cur_dark = act_blank[i] || sup[i];
            end
        end
    end

    seg_decode u_dec (
        .code     (cur_code),
        .hex_mode (HEX),
        .seg      (cur_seg)
    );

    seg_t                seg_q;
    logic                dp_q;
    logic [N_DIGITS-1:0] an_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else if (!enable) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else begin
            seg_q <= cur_dark ? SEG_BLANK : cur_seg;
            dp_q  <= cur_dp && !cur_dark;
            an_q  <= N_DIGITS'(1) << idx;
        end
    end

    assign seg_out = seg_q ^ SEG_INV;
    assign dp_out  = dp_q ^ DP_INV;
    assign an_out  = an_q ^ AN_INV;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: random and directed checks of two
// seven_seg_scan instances against a frame-level model.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic       fd_a, fd_b;

    int total = 0;
    int bad   = 0;

    seven_seg_scan #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(1),
        .SEG_ACTIVE_HIGH(1), .AN_ACTIVE_HIGH(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .lz_suppress(lz), .seg_out(seg_a), .dp_out(dp_a),
        .an_out(an_a), .frame_done(fd_a)
    );

    seven_seg_scan #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(0),
        .SEG_ACTIVE_HIGH(0), .AN_ACTIVE_HIGH(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .lz_suppress(lz), .seg_out(seg_b), .dp_out(dp_b),
        .an_out(an_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want,
                     $time);
        end
    endtask

    // Reference patterns straight from the display table.
    logic [6:0] tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Model: what is shown is the digit at (enabled cycles / DIV) mod N.
    logic [15:0] m_dig = '0, p_dig = '0;
    logic [3:0]  m_dp = '0, p_dp = '0;
    logic [3:0]  m_bl = '1, p_bl = '1;
    bit          p_val = 0;
    int          cnt = 0;
    bit          e_on = 0;
    int          e_k = 0;
    logic [6:0]  e_sa = '0, e_sb = '0;
    bit          e_dp = 0;

    initial begin : model
        int pos, k;
        bit bnd, dark;
        logic [3:0] code;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_dig = '0; m_dp = '0; m_bl = '1;
                p_dig = '0; p_dp = '0; p_bl = '1;
                p_val = 0; cnt = 0; e_on = 0;
            end else begin
                pos  = cnt % FRAME;
                k    = pos / DIV;
                code = m_dig[4*k +: 4];
                dark = m_bl[k] ||
                       (lz && k > 0 && (m_dig >> (4 * k)) == 16'd0);
                e_on = enable;
                e_k  = k;
                e_sa = dark ? 7'd0 : tbl[code];
                e_sb = (dark || code > 4'd9) ? 7'd0 : tbl[code];
                e_dp = m_dp[k] && !dark;
                bnd  = !enable || pos == FRAME - 1;
                if (load) begin
                    p_dig = digits_in; p_dp = dp_in; p_bl = blank_in;
                end
                if (bnd) begin
                    if (load) begin
                        m_dig = digits_in; m_dp = dp_in; m_bl = blank_in;
                    end else if (p_val) begin
                        m_dig = p_dig; m_dp = p_dp; m_bl = p_bl;
                    end
                    p_val = 0;
                end else if (load) begin
                    p_val = 1;
                end
                cnt = enable ? cnt + 1 : 0;
            end
        end
    end

    initial begin : compare
        logic [3:0] oh;
        logic       fd;
        forever begin
            @(negedge clk);
            #3;
            oh = e_on ? 4'(1 << e_k) : 4'd0;
            fd = rst_n && enable && (cnt % FRAME == FRAME - 1);
            chk("cyc_a", {seg_a, dp_a, an_a, fd_a},
                {(e_on ? e_sa : 7'd0), e_on && e_dp, ~oh, fd});
            chk("cyc_b", {seg_b, dp_b, an_b, fd_b},
                {~(e_on ? e_sb : 7'd0), !(e_on && e_dp), oh, fd});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frame();
        int i;
        for (i = 0; i < 100; i++) begin
            step();
            if (fd_a) break;
        end
        if (i >= 100) begin
            total++;
            bad++;
            $display("FAIL frame_wait got=timeout want=frame_done");
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] b);
        digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin : stim
        rst_n = 1'b1; enable = 1'b0; load = 1'b0; lz = 1'b0;
        digits_in = '0; dp_in = '0; blank_in = '0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_seg_a", seg_a, 7'b0000000);
        chk("rst_an_a", an_a, 4'b1111);
        chk("rst_dp_a", dp_a, 1'b0);
        chk("rst_fd", fd_a, 1'b0);
        chk("rst_seg_b", seg_b, 7'b1111111);
        chk("rst_an_b", an_b, 4'b0000);

        rst_n = 1'b1; enable = 1'b1;
        wait_frame();
        step(); step();
        chk("blank_d0_seg", seg_a, 7'b0000000);
        chk("blank_d0_an", an_a, 4'b1110);
        repeat (4) step();
        chk("blank_d1_an", an_a, 4'b1101);

        step();
        do_load(16'h1234, 4'h0, 4'h0);
        chk("hold_old", seg_a, 7'b0000000);
        wait_frame();
        step(); step();
        chk("d0_4", {seg_a, an_a}, {7'b0110011, 4'b1110});
        repeat (4) step();
        chk("d1_3", {seg_a, an_a}, {7'b1111001, 4'b1101});
        repeat (4) step();
        chk("d2_2", {seg_a, an_a}, {7'b1101101, 4'b1011});
        repeat (4) step();
        chk("d3_1", {seg_a, an_a}, {7'b0110000, 4'b0111});

        step();
        do_load(16'hAF09, 4'h1, 4'h0);
        wait_frame();
        step(); step();
        chk("hex_d0_a", {seg_a, dp_a}, {7'b1111011, 1'b1});
        chk("hex_d0_b", {seg_b, dp_b}, {7'b0000100, 1'b0});
        repeat (4) step();
        chk("hex_d1_a", seg_a, 7'b1111110);
        chk("hex_d1_b", seg_b, 7'b0000001);
        repeat (4) step();
        chk("hex_d2_a", seg_a, 7'b1000111);
        chk("hex_d2_b", seg_b, 7'b1111111);
        repeat (4) step();
        chk("hex_d3_a", seg_a, 7'b1110111);
        chk("hex_d3_b", {seg_b, an_b}, {7'b1111111, 4'b1000});

        step();
        lz = 1'b1;
        do_load(16'h0050, 4'h0, 4'h0);
        wait_frame();
        step(); step();
        chk("lz_d0", seg_a, 7'b1111110);
        repeat (4) step();
        chk("lz_d1", seg_a, 7'b1011011);
        repeat (4) step();
        chk("lz_d2", seg_a, 7'b0000000);
        repeat (4) step();
        chk("lz_d3", {seg_a, an_a}, {7'b0000000, 4'b0111});

        step();
        do_load(16'h0000, 4'h0, 4'h0);
        wait_frame();
        step(); step();
        chk("lz0_d0", seg_a, 7'b1111110);
        repeat (4) step();
        chk("lz0_d1", seg_a, 7'b0000000);

        wait_frame();
        do_load(16'h9999, 4'h0, 4'h0);
        step();
        chk("bypass_d0", seg_a, 7'b1111011);
        repeat (4) step();
        chk("bypass_d1", seg_a, 7'b1111011);

        repeat (3) step();
        enable = 1'b0;
        step();
        chk("dis_out", {seg_a, an_a, fd_a}, {7'b0000000, 4'b1111, 1'b0});
        do_load(16'h8888, 4'h0, 4'h2);
        step(); step();
        enable = 1'b1;
        repeat (6) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_a", {seg_a, an_a}, {7'b0000000, 4'b1111});
        chk("async_b", {seg_b, an_b}, {7'b1111111, 4'b0000});
        step(); step();
        rst_n = 1'b1;
        step();
        chk("restart_d0", {seg_a, an_a}, {7'b0000000, 4'b1110});
        repeat (4) step();
        chk("restart_d1", {seg_a, an_a}, {7'b0000000, 4'b1101});

        lz = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            step();
            if ($urandom_range(99) == 0) enable = !enable;
            if ($urandom_range(49) == 0) lz = !lz;
            load = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0: digits_in = 16'($urandom);
                1: digits_in = 16'($urandom) & 16'h00FF;
                2: digits_in = 16'($urandom) & 16'h000F;
                default: digits_in = 16'h0000;
            endcase
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
        end
        load = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
